ifetch_arbiter: RTL and testbench

Fetch controller and arbiter for the combinational 32-bit instruction ROM. It owns the program counter and sequences instruction fetch into the IF/ID register, applying stall, redirect (branch/jump) and halt. It also shares the single ROM read port with a debug read requester. Starvation of the debug port is bounded by a stolen fetch slot.

---
 rtl/ifetch_arbiter_pkg.sv | 20 ++
 rtl/ifetch_arbiter_if.sv | 24 ++
 rtl/ifetch_arbiter_grant.sv | 35 +++
 rtl/ifetch_arbiter.sv | 131 +++++++++++++
 tb/tb_ifetch_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifetch_arbiter_pkg.sv
// Shared types and constants for the instruction fetch controller and its
// debug-read arbiter.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // The ROM is word-addressed, so every byte address is truncated to its word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_arbiter_if.sv
// Debug read port sharing the instruction ROM. The requester holds dbg_req
// until it sees the one-cycle dbg_ack pulse, which qualifies dbg_data.
interface ifetch_arbiter_if;

  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  modport master (
    output dbg_req,
    output dbg_addr,
    input  dbg_ack,
    input  dbg_data
  );

  modport slave (
    input  dbg_req,
    input  dbg_addr,
    output dbg_ack,
    output dbg_data
  );

endinterface

// File: rtl/ifetch_arbiter_grant.sv
// Debug grant decision for the shared ROM port. A debug read is granted whenever
// the CPU is not fetching, or is forced in after STARVE_LIMIT denied cycles.
module ifetch_grant #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic dbg_req,
  input  logic dbg_ack,
  input  logic in_run,
  input  logic stall,
  output logic grant
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == LIMIT);

  // dbg_ack gating makes the requester drop dbg_req before a second read is served.
  assign grant = dbg_req && !dbg_ack && (!in_run || stall || starved);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (grant || !dbg_req) begin
      starve_cnt <= 4'd0;
    end else if (in_run && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/ifetch_arbiter.sv
// Fetch controller: owns the PC, sequences ROM fetch into the IF/ID register
// and lends the ROM read port to the debug requester.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | first cycle after reset release, no fetch yet
//   RUN    | fetching one instruction per cycle unless stalled/stolen
//   HALTED | no CPU fetch; debug reads served immediately
module ifetch_arbiter
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int          STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    halt_req,
  input  logic                    resume,
  ifetch_arbiter_if.slave         dbg,
  output logic [31:0]             rom_pc,
  input  logic [31:0]             rom_inst,
  output logic                    if_valid,
  output logic [31:0]             if_pc,
  output logic [31:0]             if_inst,
  output logic                    halted,
  output logic                    fetch_err
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q;
  logic         in_run;
  logic         grant;
  logic         fetch;
  logic         stolen;

  assign in_run = (state_q == RUN);

  ifetch_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .dbg_req (dbg.dbg_req),
    .dbg_ack (dbg.dbg_ack),
    .in_run  (in_run),
    .stall   (stall),
    .grant   (grant)
  );

  assign fetch  = in_run && !stall && !grant;
  assign stolen = in_run && !stall && grant;

  assign rom_pc = grant ? word_align(dbg.dbg_addr) : pc_q;
  assign halted = (state_q == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = halt_req ? HALTED : RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (resume && !halt_req) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Redirect owns the PC in every state and beats both fetch and stolen slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= word_align(redirect_pc);
    end else if (fetch) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid <= 1'b0;
      if_pc    <= 32'h0;
      if_inst  <= NOP_INST;
    end else begin
      if (redirect) begin
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_valid <= fetch;
      end
      if (fetch && !redirect) begin
        if_pc   <= pc_q;
        if_inst <= rom_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg.dbg_ack  <= 1'b0;
      dbg.dbg_data <= 32'h0;
    end else begin
      dbg.dbg_ack <= grant;
      if (grant) begin
        dbg.dbg_data <= rom_inst;
      end
    end
  end

  // Sticky until reset so software can find out a bad target was ever taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      fetch_err <= 1'b1;
    end
  end

  // Only visible in simulation builds; documents that stolen slots never advance the PC.
  logic unused_stolen;
  assign unused_stolen = stolen;

endmodule

// File: tb/tb_ifetch_arbiter.sv
// Directed bench for ifetch_arbiter: a fetch scoreboard checks every delivered
// instruction while the directed sequence probes debug, redirect, halt and reset.
module tb_ifetch_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        resume;
  logic [31:0] rom_pc;
  logic [31:0] rom_inst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        halted;
  logic        fetch_err;

  ifetch_arbiter_if dbg_bus ();

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch_arbiter #(
    .RESET_PC     (32'h0000_0000),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_req    (halt_req),
    .resume      (resume),
    .dbg         (dbg_bus.slave),
    .rom_pc      (rom_pc),
    .rom_inst    (rom_inst),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_inst     (if_inst),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a[31:2])
      30'd11:  return 32'h2008_FFFF;
      30'd12:  return 32'hAC08_0000;
      30'd85:  return 32'h35EF_F3F4;
      default: return 32'hC0DE_0000 | {18'b0, a[15:2]};
    endcase
  endfunction

  assign rom_inst = rom_word(rom_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // A valid IF/ID after an edge with stall low is always a freshly fetched word.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && stall === 1'b0 && if_valid === 1'b1) begin
      chk("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_if_pc", if_pc, e);
        chk("sb_if_inst", if_inst, rom_word(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    halt_req = 1'b0;
    resume = 1'b0;
    dbg_bus.dbg_req = 1'b0;
    dbg_bus.dbg_addr = 32'h0;
    #3;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_dbg_ack", 32'(dbg_bus.dbg_ack), 32'd0);
    chk("rst_dbg_data", dbg_bus.dbg_data, 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_rom_pc", rom_pc, 32'h0);
    tick();
    tick();

    // Sequential fetch from reset
    for (int a = 0; a <= 48; a += 4) exp_q.push_back(32'(a));
    rst_n = 1'b1;
    tick();
    chk("idle_no_valid", 32'(if_valid), 32'd0);
    repeat (12) tick();
    chk("seq_pc44", if_pc, 32'd44);
    chk("seq_inst44", if_inst, 32'h2008_FFFF);
    tick();
    chk("seq_pc48", if_pc, 32'd48);
    chk("seq_inst48", if_inst, 32'hAC08_0000);

    // Aligned redirect squashes the in-flight slot
    redirect = 1'b1;
    redirect_pc = 32'd340;
    exp_q.push_back(32'd340);
    tick();
    chk("redir_squash", 32'(if_valid), 32'd0);
    redirect = 1'b0;
    tick();
    chk("redir_pc", if_pc, 32'd340);
    chk("redir_inst", if_inst, 32'h35EF_F3F4);

    // Debug read during stall
    stall = 1'b1;
    dbg_bus.dbg_req = 1'b1;
    dbg_bus.dbg_addr = 32'd49;
    #1;
    chk("stall_dbg_rom_pc", rom_pc, 32'd48);
    tick();
    chk("stall_dbg_ack", 32'(dbg_bus.dbg_ack), 32'd1);
    chk("stall_dbg_data", dbg_bus.dbg_data, 32'hAC08_0000);
    chk("stall_hold_pc", if_pc, 32'd340);
    chk("stall_hold_inst", if_inst, 32'h35EF_F3F4);
    chk("stall_hold_valid", 32'(if_valid), 32'd1);
    tick();
    chk("dbg_ack_single", 32'(dbg_bus.dbg_ack), 32'd0);
    dbg_bus.dbg_req = 1'b0;
    stall = 1'b0;
    exp_q.push_back(32'd344);
    tick();

    // Starvation: slot stolen on the fifth denied request cycle
    dbg_bus.dbg_req = 1'b1;
    dbg_bus.dbg_addr = 32'h0000_0100;
    for (int a = 348; a <= 364; a += 4) exp_q.push_back(32'(a));
    repeat (3) tick();
    chk("starve_not_yet", rom_pc, 32'd360);
    tick();
    chk("starve_grant_rom_pc", rom_pc, 32'h0000_0100);
    tick();
    chk("steal_bubble", 32'(if_valid), 32'd0);
    chk("steal_ack", 32'(dbg_bus.dbg_ack), 32'd1);
    chk("steal_data", dbg_bus.dbg_data, rom_word(32'h0000_0100));
    dbg_bus.dbg_req = 1'b0;
    tick();
    chk("steal_resume_pc", if_pc, 32'd364);

    // Misaligned redirect
    redirect = 1'b1;
    redirect_pc = 32'd46;
    tick();
    chk("misalign_err", 32'(fetch_err), 32'd1);
    chk("misalign_squash", 32'(if_valid), 32'd0);
    redirect = 1'b0;
    exp_q.push_back(32'd44);
    tick();
    chk("misalign_pc", if_pc, 32'd44);
    chk("misalign_sticky", 32'(fetch_err), 32'd1);

    // Halt, debug read while halted, resume
    halt_req = 1'b1;
    exp_q.push_back(32'd48);
    tick();
    chk("halt_entered", 32'(halted), 32'd1);
    halt_req = 1'b0;
    tick();
    chk("halt_no_valid", 32'(if_valid), 32'd0);
    chk("halt_stays", 32'(halted), 32'd1);
    dbg_bus.dbg_req = 1'b1;
    dbg_bus.dbg_addr = 32'd340;
    #1;
    chk("halt_dbg_rom_pc", rom_pc, 32'd340);
    tick();
    chk("halt_dbg_ack", 32'(dbg_bus.dbg_ack), 32'd1);
    chk("halt_dbg_data", dbg_bus.dbg_data, 32'h35EF_F3F4);
    dbg_bus.dbg_req = 1'b0;
    resume = 1'b1;
    tick();
    chk("resume_left_halt", 32'(halted), 32'd0);
    resume = 1'b0;
    exp_q.push_back(32'd52);
    tick();
    chk("resume_held_pc", if_pc, 32'd52);

    // Halt beats resume when both are high
    halt_req = 1'b1;
    resume = 1'b1;
    exp_q.push_back(32'd56);
    tick();
    chk("both_halt", 32'(halted), 32'd1);
    tick();
    chk("both_halt_wins", 32'(halted), 32'd1);
    halt_req = 1'b0;
    tick();
    chk("resume_only", 32'(halted), 32'd0);
    resume = 1'b0;
    exp_q.push_back(32'd60);
    tick();

    // Reset mid-run with a pending debug read
    dbg_bus.dbg_req = 1'b1;
    dbg_bus.dbg_addr = 32'd44;
    exp_q.push_back(32'd64);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    chk("mid_rst_if_pc", if_pc, 32'h0);
    chk("mid_rst_if_inst", if_inst, 32'h0);
    chk("mid_rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("mid_rst_ack", 32'(dbg_bus.dbg_ack), 32'd0);
    chk("mid_rst_data", dbg_bus.dbg_data, 32'h0);
    chk("mid_rst_halted", 32'(halted), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_rom_pc", rom_pc, 32'd44);
    tick();
    chk("post_rst_ack", 32'(dbg_bus.dbg_ack), 32'd1);
    chk("post_rst_data", dbg_bus.dbg_data, 32'h2008_FFFF);
    chk("post_rst_no_valid", 32'(if_valid), 32'd0);
    dbg_bus.dbg_req = 1'b0;
    exp_q.push_back(32'd0);
    tick();
    chk("post_rst_pc0", if_pc, 32'd0);
    chk("post_rst_valid", 32'(if_valid), 32'd1);
    stall = 1'b1;
    tick();
    tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
